// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Provides the fetch FSM state enum, fault cause codes and bus response codes.
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD,
        WAIT_PC
    } ifu_state_e;

    localparam logic       CAUSE_MISALIGN = 1'b0;
    localparam logic       CAUSE_ACCESS   = 1'b1;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: fetches one instruction at the writeback PC.
// Ports: sys_clk/sys_rst, pc/pc_upd from writeback, AR/R read bus, inst_* to decode.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_upd,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic              inst_cause,
    output logic              inst_valid,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ifu_state_e       state;
    logic [CNT_W-1:0] cnt;
    // sticky: pc_upd seen during the decode handshake
    // pend:   pc_upd seen in WAIT_PC; new pc is valid next cycle
    logic             sticky;
    logic             pend;
    logic             launch;

    assign launch = (state == IDLE) || (state == WAIT_PC && pend);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sticky     <= 1'b0;
            pend       <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
            inst_cause <= 1'b0;
            inst_valid <= 1'b0;
        end else if (launch) begin
            inst_pc <= pc;
            sticky  <= 1'b0;
            pend    <= 1'b0;
            if (pc[1:0] != 2'b00) begin
                inst       <= '0;
                inst_fault <= 1'b1;
                inst_cause <= CAUSE_MISALIGN;
                inst_valid <= 1'b1;
                state      <= HOLD;
            end else begin
                araddr  <= pc;
                arvalid <= 1'b1;
                state   <= ADDR;
            end
        end else begin
            unique case (state)
                ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        cnt     <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                        if (rresp == RESP_OKAY) begin
                            inst       <= rdata;
                            inst_fault <= 1'b0;
                        end else begin
                            inst       <= '0;
                            inst_fault <= 1'b1;
                            inst_cause <= CAUSE_ACCESS;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // timed out: report as an access fault
                        rready     <= 1'b0;
                        inst       <= '0;
                        inst_fault <= 1'b1;
                        inst_cause <= CAUSE_ACCESS;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        sticky     <= pc_upd;
                        state      <= WAIT_PC;
                    end
                end
                WAIT_PC: begin
                    if (pc_upd || sticky) begin
                        pend   <= 1'b1;
                        sticky <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch with a small AR/R slave model.
// Expected fetch addresses and decode outputs are queued by the stimulus.
module tb_ifu_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        pc_upd = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_cause;
    logic        inst_valid;
    logic        inst_ready = 1'b1;

    ifu_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .pc(pc), .pc_upd(pc_upd),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .inst_cause(inst_cause), .inst_valid(inst_valid),
        .inst_ready(inst_ready)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
        logic        cause;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_addr[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          ar_hs  = 0;
    int          late_hs = 0;
    logic        slv_busy = 1'b0;
    int          slv_ar_wait = 0;
    int          slv_r_delay = 0;
    logic [31:0] slv_data = 32'h0;
    logic [1:0]  slv_resp = 2'b00;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p,
                                input logic f, input logic c);
        exp_t e;
        e.inst = i; e.pc = p; e.fault = f; e.cause = c;
        return e;
    endfunction

    // Decode-side monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            #2;
            if (inst_valid && inst_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_inst", {32'h0, inst_pc}, 64'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    check("inst", {32'h0, inst}, {32'h0, e.inst});
                    check("inst_pc", {32'h0, inst_pc}, {32'h0, e.pc});
                    check("inst_fault", {63'h0, inst_fault}, {63'h0, e.fault});
                    if (e.fault)
                        check("inst_cause", {63'h0, inst_cause}, {63'h0, e.cause});
                end
            end
        end
    end

    // Bus slave model
    initial begin
        logic [31:0] a;
        logic        abort;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        forever begin
            @(negedge sys_clk);
            if (arvalid && !sys_rst) begin
                slv_busy = 1'b1;
                abort = 1'b0;
                if (exp_addr.size() == 0) begin
                    check("unexpected_fetch", {32'h0, araddr}, 64'hffff_ffff);
                    a = araddr;
                end else begin
                    a = exp_addr.pop_front();
                    check("araddr", {32'h0, araddr}, {32'h0, a});
                end
                for (int i = 0; i < slv_ar_wait; i++) begin
                    @(negedge sys_clk);
                    check("ar_hold", {31'h0, arvalid, araddr}, {31'h0, 1'b1, a});
                end
                arready = 1'b1;
                ar_hs++;
                @(negedge sys_clk);
                arready = 1'b0;
                for (int i = 0; i < slv_r_delay; i++) begin
                    if (sys_rst) abort = 1'b1;
                    if (!abort) @(negedge sys_clk);
                end
                if (sys_rst) abort = 1'b1;
                if (!abort) begin
                    rvalid = 1'b1; rdata = slv_data; rresp = slv_resp;
                    #2;
                    if (!rready) late_hs++;
                    @(negedge sys_clk);
                    rvalid = 1'b0;
                end
                slv_busy = 1'b0;
            end
        end
    end

    task automatic upd(input logic [31:0] npc);
        pc_upd = 1'b1;
        @(negedge sys_clk);
        pc_upd = 1'b0;
        pc = npc;
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!inst_valid && c < 60) begin
            @(negedge sys_clk);
            c++;
        end
        if (!inst_valid) check(name, 64'h0, 64'h1);
    endtask

    task automatic wait_rready();
        int c;
        c = 0;
        while (!rready && c < 30) begin
            @(negedge sys_clk);
            c++;
        end
    endtask

    task automatic wait_slave();
        int c;
        c = 0;
        while (slv_busy && c < 60) begin
            @(negedge sys_clk);
            c++;
        end
    endtask

    initial begin
        int          lat;
        int          n;
        int          hs0;
        logic [31:0] held;

        repeat (2) @(negedge sys_clk);
        check("rst_bus", {61'h0, arvalid, rready, inst_valid}, 64'h0);
        check("rst_inst", {inst, inst_pc}, 64'h0);
        check("rst_flags", {62'h0, inst_fault, inst_cause}, 64'h0);

        // Basic fetch and latency
        pc = 32'h8000_0000;
        slv_data = 32'h0000_0413;
        exp_addr.push_back(32'h8000_0000);
        sb.push_back(mk(32'h0000_0413, 32'h8000_0000, 1'b0, 1'b0));
        sys_rst = 1'b0;
        lat = 0;
        while (!inst_valid && lat < 20) begin
            @(negedge sys_clk);
            lat++;
        end
        check("latency", 64'(lat), 64'd3);
        @(negedge sys_clk);

        // arready stalled 4 cycles
        hs0 = ar_hs;
        slv_ar_wait = 4;
        slv_data = 32'h0011_0093;
        exp_addr.push_back(32'h8000_0004);
        sb.push_back(mk(32'h0011_0093, 32'h8000_0004, 1'b0, 1'b0));
        upd(32'h8000_0004);
        wait_valid("valid_arstall");
        check("ar_single", 64'(ar_hs - hs0), 64'd1);
        slv_ar_wait = 0;
        wait_slave();

        // Decode back-pressure; stray pc_upd in HOLD is ignored
        inst_ready = 1'b0;
        slv_data = 32'h0020_0113;
        exp_addr.push_back(32'h8000_0008);
        sb.push_back(mk(32'h0020_0113, 32'h8000_0008, 1'b0, 1'b0));
        upd(32'h8000_0008);
        wait_valid("valid_hold");
        held = inst;
        for (int i = 0; i < 5; i++) begin
            pc_upd = (i == 1);
            @(negedge sys_clk);
            check("hold_stable", {31'h0, inst_valid, inst}, {31'h0, 1'b1, held});
        end
        pc_upd = 1'b0;
        inst_ready = 1'b1;
        repeat (8) @(negedge sys_clk);

        // Misaligned PC: no bus request
        hs0 = ar_hs;
        sb.push_back(mk(32'h0, 32'h8000_0002, 1'b1, 1'b0));
        upd(32'h8000_0002);
        wait_valid("valid_misalign");
        check("misalign_no_ar", 64'(ar_hs - hs0), 64'd0);
        @(negedge sys_clk);

        // Error response
        slv_data = 32'hdead_beef;
        slv_resp = 2'b10;
        exp_addr.push_back(32'h8000_000c);
        sb.push_back(mk(32'h0, 32'h8000_000c, 1'b1, 1'b1));
        upd(32'h8000_000c);
        wait_valid("valid_slverr");
        wait_slave();
        slv_resp = 2'b00;

        // Timeout, then a late rvalid that must be ignored
        slv_r_delay = 20;
        slv_data = 32'h1234_5678;
        late_hs = 0;
        exp_addr.push_back(32'h8000_0010);
        sb.push_back(mk(32'h0, 32'h8000_0010, 1'b1, 1'b1));
        upd(32'h8000_0010);
        wait_rready();
        n = 0;
        while (rready && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd8);
        wait_valid("valid_timeout");
        wait_slave();
        check("late_rvalid_ignored", 64'(late_hs), 64'd1);
        check("late_rready_low", {63'h0, rready}, 64'h0);
        @(negedge sys_clk);

        // Reset while in DATA
        exp_addr.push_back(32'h8000_0014);
        upd(32'h8000_0014);
        wait_rready();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("rst_data", {61'h0, arvalid, rready, inst_valid}, 64'h0);
        repeat (3) @(negedge sys_clk);
        wait_slave();
        slv_r_delay = 0;
        slv_data = 32'h0030_0193;
        exp_addr.push_back(32'h8000_0014);
        sb.push_back(mk(32'h0030_0193, 32'h8000_0014, 1'b0, 1'b0));
        sys_rst = 1'b0;
        wait_valid("valid_after_rst");
        @(negedge sys_clk);
        wait_slave();

        // pc_upd coincident with the decode handshake
        hs0 = ar_hs;
        inst_ready = 1'b0;
        slv_data = 32'h0040_0213;
        exp_addr.push_back(32'h8000_0018);
        sb.push_back(mk(32'h0040_0213, 32'h8000_0018, 1'b0, 1'b0));
        upd(32'h8000_0018);
        wait_valid("valid_sticky0");
        slv_data = 32'h0050_0293;
        exp_addr.push_back(32'h8000_001c);
        sb.push_back(mk(32'h0050_0293, 32'h8000_001c, 1'b0, 1'b0));
        inst_ready = 1'b1;
        upd(32'h8000_001c);
        wait_valid("valid_sticky1");
        repeat (12) @(negedge sys_clk);
        check("sticky_one_fetch", 64'(ar_hs - hs0), 64'd2);

        check("sb_empty", 64'(sb.size()), 64'd0);
        check("addr_empty", 64'(exp_addr.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly upstream of the writeback/register-file unit.
- Samples the architectural `pc` that the writeback stage produces and fetches one 32-bit instruction over a read-only valid/ready bus (AR/R channels).
- Presents the instruction, with its PC and a fault indication, to the decode stage under a valid/ready handshake.
- Multi-cycle, one instruction in flight; the next fetch starts only after the writeback stage reports the PC update.

Parameters:
- ADDR_W, 32, bus address and PC width
- DATA_W, 32, bus data and instruction width
- TIMEOUT, 255, maximum cycles in DATA waiting for rvalid before an access fault is raised (must be ≥1)

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset
- pc  in  ADDR_W  current PC from the writeback stage
- pc_upd  in  1  pulse in the cycle the writeback stage applies pc_wen or pc_add_en
- araddr  out  ADDR_W  fetch address
- arvalid  out  1  address valid
- arready  in  1  address accepted
- rdata  in  DATA_W  read data
- rresp  in  2  response; 2'b00 is OKAY
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- inst  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  PC of `inst`
- inst_fault  out  1  fetch faulted
- inst_cause  out  1  0 = misaligned, 1 = access fault (valid only when inst_fault = 1)
- inst_valid  out  1  instruction valid to decode
- inst_ready  in  1  decode accepts

Behaviour:
- Reset is asynchronous and active-high on sys_rst; the clock is sys_clk. Reset forces state IDLE. All outputs are 0 on reset, including arvalid, rready, inst_valid, inst, inst_pc, inst_fault, inst_cause and the timeout counter.
- Reset mid-operation abandons any outstanding bus transaction. The bus slave is reset by the same sys_rst.
- States: IDLE, ADDR, DATA, HOLD, WAIT_PC.
- IDLE: on the first cycle after reset release, go to LAUNCH.
- LAUNCH (the entry action for ADDR):
  - Latch inst_pc <= pc.
  - If pc[1:0] != 0: no bus request; inst_fault = 1, inst_cause = 0, inst = 0; go to HOLD.
  - Otherwise: araddr <= pc, arvalid <= 1; go to ADDR.
- ADDR:
  - arvalid stays high and araddr stays stable until arready.
  - On arvalid && arready: arvalid <= 0, rready <= 1, timeout counter <= 0; go to DATA.
- DATA:
  - On rvalid: rready <= 0; go to HOLD.
    - If rresp == 0: inst <= rdata, inst_fault <= 0.
    - If rresp != 0: inst <= 0, inst_fault <= 1, inst_cause <= 1.
  - Otherwise the counter increments. When the counter reaches TIMEOUT - 1 with no rvalid: treat as rresp != 0, drop rready, go to HOLD.
  - An rvalid arriving after a timeout is ignored, because rready is low.
- HOLD:
  - inst_valid = 1; inst, inst_pc, inst_fault and inst_cause are held stable.
  - On inst_ready: inst_valid <= 0; go to WAIT_PC.
- WAIT_PC:
  - Wait for pc_upd. The new pc is visible the cycle after pc_upd.
  - In the cycle after pc_upd, perform LAUNCH.
  - pc_upd arriving in any state other than WAIT_PC is ignored.
  - pc_upd in the same cycle as the inst_ready handshake is captured by a sticky flag, so LAUNCH occurs on the cycle after next. The flag clears on LAUNCH.
- Latency (zero-wait bus, arready = 1 and rvalid the cycle after the AR handshake):
  - Launch cycle to inst_valid is 3 cycles.
  - inst_valid to the next arvalid, with pc_upd one cycle after the handshake, is 2 cycles.
- Throughput: at most one instruction in flight; no prefetch.
- arvalid and inst_valid must never depend combinationally on arready, rvalid or inst_ready. All outputs are registered.

Decomposition:
- Shared package `ifu_pkg`:
  - state enum ifu_state_e {IDLE, ADDR, DATA, HOLD, WAIT_PC}
  - constants CAUSE_MISALIGN = 1'b0, CAUSE_ACCESS = 1'b1, RESP_OKAY = 2'b00
- No sub-module; the timeout counter is inline, $clog2(TIMEOUT+1) bits wide.

Test Plan:
- Reset, then pc = 0x80000000, arready = 1, rvalid the next cycle with rdata = 0x00000413, rresp = 0 -> inst_valid with inst = 0x00000413, inst_pc = 0x80000000, inst_fault = 0; launch to valid is 3 cycles.
- arready low for 4 cycles -> araddr is stable at 0x80000004 and arvalid stays high throughout; a single AR handshake occurs.
- inst_ready low for 5 cycles in HOLD -> inst_valid and inst stay stable; after pc_upd with pc = 0x80000008 the next araddr is 0x80000008; no fetch occurs before pc_upd.
- pc = 0x80000002 -> no arvalid; inst_fault = 1, inst_cause = 0, inst = 0, inst_pc = 0x80000002.
- rresp = 2'b10 -> inst_fault = 1, inst_cause = 1, inst = 0. With TIMEOUT = 8 and rvalid never asserted -> fault after 8 DATA cycles, rready drops, and a late rvalid is ignored.
- Assert sys_rst while in DATA -> arvalid, rready and inst_valid go to 0 immediately; after release the fetch restarts from the current pc. pc_upd coincident with the inst_ready handshake -> exactly one new fetch.
